// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer: next-PC modes, FSM states,
// and the instruction size in bytes.
package pc_pkg;

  // Next-PC mode selector driven by the control unit.
  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-fetch-address calculator. All arithmetic wraps modulo 2^WIDTH.
module npc_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       npc_op,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [WIDTH-1:0] rs_val,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misaligned
);

  // Low 28 bits of the address are replaced by a J-type target; the rest come from pc+4.
  localparam logic [31:0]      Low28    = 32'h0FFF_FFFF;
  localparam logic [WIDTH-1:0] LowMask  = Low28[WIDTH-1:0];

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jump_lo;

  assign pc_plus4 = pc + WIDTH'(INSTR_BYTES);
  // Word offset sign-extended and scaled to bytes.
  assign br_off   = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign jump_lo  = WIDTH'({target26, 2'b00});

  // Select next fetch address by mode; JR flags a target with nonzero byte offset.
  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    unique case (npc_op)
      NPC_SEQ:    next_pc = pc_plus4;
      NPC_BRANCH: next_pc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
      NPC_JUMP:   next_pc = (pc_plus4 & ~LowMask) | jump_lo;
      NPC_JR: begin
        next_pc    = {rs_val[WIDTH-1:2], 2'b00};
        misaligned = |rs_val[1:0];
      end
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, BOOT/RUN/HALT control and sticky
// misaligned-JR error flag. The next address comes from npc_calc.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       npc_op,
  input  logic             br_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             stall,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid,
  output logic             halted,
  output logic             misalign_err
);

  state_e           state;
  logic [WIDTH-1:0] next_pc;
  logic             misaligned;

  npc_calc #(
    .WIDTH (WIDTH)
  ) u_npc_calc (
    .pc         (pc),
    .npc_op     (npc_op),
    .br_taken   (br_taken),
    .imm16      (imm16),
    .target26   (target26),
    .rs_val     (rs_val),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  // FSM with registered pc, valid, halted and sticky error; stall outranks halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BOOT;
      pc           <= RESET_VECTOR;
      valid        <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          valid <= 1'b1;
        end
        ST_RUN: begin
          if (stall) begin
            // Hold; a concurrent halt is dropped and must be re-presented.
          end else if (halt) begin
            state  <= ST_HALT;
            valid  <= 1'b0;
            halted <= 1'b1;
          end else begin
            pc <= next_pc;
            if (misaligned) misalign_err <= 1'b1;
          end
        end
        ST_HALT: begin
          // Frozen until reset.
        end
        default: begin
          state  <= ST_BOOT;
          pc     <= RESET_VECTOR;
          valid  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle datapath: it holds the architectural PC and computes the next fetch address each cycle. It supports sequential, conditional-branch, absolute-jump and jump-register modes, plus stall, halt and a misaligned-target error flag. It sits between the control unit/ALU (branch decision, immediates, register operand) and instruction memory (fetch address).

## Interface
- WIDTH, 32, PC/address width in bits; legal range is 28 to 32.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- npc_op  in  2  next-PC mode: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR.
- br_taken  in  1  branch condition from ALU; used only when npc_op=BRANCH.
- imm16  in  16  branch offset in words, signed.
- target26  in  26  J-type word target.
- rs_val  in  WIDTH  register operand for JR.
- stall  in  1  hold PC this cycle.
- halt  in  1  halt request (halt instruction decoded).
- pc  out  WIDTH  current fetch address, registered.
- pc_plus4  out  WIDTH  pc+4, combinational, for link writes.
- valid  out  1  high when the PC is in RUN and the fetch is architectural.
- halted  out  1  high in HALT.
- misalign_err  out  1  sticky; set when a JR target has a nonzero [1:0].

## Operation
- State machine has three states: BOOT, RUN, HALT.
  - BOOT: entered on rst. pc=RESET_VECTOR and all inputs are ignored. Moves to RUN on the next cycle unconditionally, with pc unchanged, so the first fetch is at RESET_VECTOR.
  - RUN: pc advances each cycle per the priority list below.
  - HALT: pc frozen and inputs ignored. The only exit is rst.
- Priority in RUN, highest first:
  1. stall: pc holds.
  2. halt: go to HALT; pc holds at the halt instruction's address.
  3. npc_op decides the next pc.
- Next-address rules. All arithmetic is modulo 2^WIDTH; carries are discarded and wrap-around is silent.
  - SEQ: pc+4.
  - BRANCH with br_taken=1: pc+4 + (sign_extend(imm16) << 2), computed at WIDTH bits.
  - BRANCH with br_taken=0: pc+4.
  - JUMP: {pc_plus4[WIDTH-1:28], target26, 2'b00}.
  - JR: {rs_val[WIDTH-1:2], 2'b00}. If rs_val[1:0]!=0, misalign_err is set the same edge pc loads and stays set until rst.
- stall and halt in the same cycle: stall wins and halt is not latched. Control must re-present halt.
- rst in any state, including mid-stall or HALT, forces BOOT on the next edge.

## Timing
- Reset values: pc=RESET_VECTOR, valid=0, halted=0, misalign_err=0, state=BOOT. pc_plus4 then reads RESET_VECTOR+4.
- Latency: the next pc is registered, so inputs sampled at edge N determine pc after edge N. There is no combinational path from inputs to pc.
- Combinational output: pc_plus4 follows pc within the same cycle.
- valid=1 exactly in RUN. It stays high during stall (the fetch is repeated, not dropped).
- halted rises one cycle after halt is accepted.
- misalign_err rises one cycle after the offending JR is accepted.

## Structure
- Shared package pc_pkg holds:
  - the npc_op encoding constants (NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_JR);
  - the state encoding (ST_BOOT, ST_RUN, ST_HALT);
  - INSTR_BYTES=4.
- One sub-module, npc_calc. It is purely combinational: it takes pc, npc_op, br_taken, imm16, target26 and rs_val, and produces next_pc, pc_plus4 and a misaligned strobe.
- pc_sequencer holds the PC register, the FSM and the sticky error flag.

## Test plan
- Reset and boot: assert rst for 2 cycles with RESET_VECTOR=32'h0040_0000, then 3 SEQ cycles. Expect pc = 0040_0000 (reset), 0040_0000 (BOOT), 0040_0004, 0040_0008; valid=0 until the first RUN cycle.
- Branch: pc=0000_0100, BRANCH with imm16=16'hFFFE and br_taken=1 → pc=0000_00FC. Same inputs with br_taken=0 → pc=0000_0104. With pc=FFFF_FFFC and SEQ → pc=0000_0000 (wrap).
- Jump and JR:
  - pc=1000_0000, JUMP with target26=26'h0000_010 → pc=1000_0040.
  - JR with rs_val=0000_2003 → pc=0000_2000 and misalign_err=1 from then until rst.
- Stall and halt:
  - stall=1 for 3 cycles under SEQ → pc is constant and valid stays 1.
  - stall=1 together with halt=1 → no halt.
  - halt=1 alone → halted=1 next cycle; pc frozen through 5 further JUMP requests.
- Reset mid-operation: rst asserted during HALT with misalign_err=1 → next edge gives pc=RESET_VECTOR, halted=0, misalign_err=0, state BOOT.
